// File: rtl/cpu_io_pkg.sv
// Shared IO-bus peripheral definitions: conf/flag bit positions and the SPI
// responder state encoding.
package cpu_io_pkg;

    localparam int unsigned CONF_CPHA = 0;
    localparam int unsigned CONF_CPOL = 1;
    localparam int unsigned CONF_LSB  = 2;

    localparam int unsigned FLAG_RX_OVERRUN  = 0;
    localparam int unsigned FLAG_TX_UNDERRUN = 1;
    localparam int unsigned FLAG_FRAME_ABORT = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } spi_state_t;

endpackage

// File: rtl/spi_slave_if.sv
// IO-bus side of the SPI responder: conf/data/status register signals.
interface spi_slave_if;

    logic [7:0] conf;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_full;
    logic [7:0] rx_data;
    logic       rx_pop;
    logic [4:0] rx_count;
    logic       busy;
    logic [2:0] flags;
    logic       clr_flags;

    modport slave (
        input  conf, tx_data, tx_load, rx_pop, clr_flags,
        output tx_full, rx_data, rx_count, busy, flags
    );

    modport master (
        output conf, tx_data, tx_load, rx_pop, clr_flags,
        input  tx_full, rx_data, rx_count, busy, flags
    );

endinterface

// File: rtl/spi_slave_rx_fifo.sv
// First-word-fall-through byte FIFO for received SPI bytes, with occupancy count.
module spi_slave_rx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_pop,
    output logic [7:0] o_data,
    output logic [4:0] o_count,
    output logic       o_full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [4:0]    r_count;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;

    assign w_empty = (r_count == 5'd0);
    assign o_full  = (r_count == 5'(DEPTH));
    // A pop frees the slot the same cycle, so a full FIFO still accepts push+pop.
    assign w_pop   = i_pop && !w_empty;
    assign w_push  = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_data  = w_empty ? '0 : r_mem[r_rd];

endmodule

// File: rtl/spi_slave.sv
// SPI responder: oversamples the SPI pins in the CPU clock domain, double-buffers
// TX through a holding register and queues received bytes in a small FIFO.
module spi_slave
    import cpu_io_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RX_DEPTH    = 4,
    parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    input  logic       spi_cs_n,
    output logic       spi_miso,
    output logic       miso_oe,
    spi_slave_if.slave bus
);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sync_vld;
    logic                   r_sclk_prev;
    logic                   r_cs_prev;

    logic w_sclk_s;
    logic w_mosi_s;
    logic w_cs_s;
    logic w_vld;
    logic w_cs_fall;
    logic w_cs_rise;
    logic w_lead;
    logic w_trail;
    logic w_active;
    logic w_sample;
    logic w_drive;

    spi_state_t r_state;
    spi_state_t w_state_nx;
    logic       w_reload;
    logic       w_push;
    logic       w_abort;
    logic       w_overrun;
    logic       w_fifo_full;

    logic       r_cpha;
    logic       r_cpol;
    logic       r_lsb;
    logic [7:0] r_shift;
    logic [7:0] r_rx;
    logic [7:0] r_tx_hold;
    logic       r_tx_full;
    logic       r_oe;
    logic [3:0] r_bitcnt;
    logic [2:0] r_flags;
    logic [2:0] w_flag_set;
    logic [2:0] w_flag_clr;
    logic       w_unused_conf;

    assign w_unused_conf = ^bus.conf[7:3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cs_sync   <= '1;
            r_sync_vld  <= '0;
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            r_sync_vld  <= {r_sync_vld[SYNC_STAGES-2:0], 1'b1};
            r_sclk_prev <= w_sclk_s;
            if (w_vld) begin
                r_cs_prev <= w_cs_s;
            end
        end
    end

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
    assign w_vld    = r_sync_vld[SYNC_STAGES-1];

    // r_cs_prev starts low and only tracks real pin samples, so a select already
    // asserted across reset release is ignored until cs_n has been seen high.
    assign w_cs_fall = w_vld && r_cs_prev && !w_cs_s;
    assign w_cs_rise = w_vld && !r_cs_prev && w_cs_s;

    assign w_lead  = (w_sclk_s != r_cpol) && (r_sclk_prev == r_cpol);
    assign w_trail = (w_sclk_s == r_cpol) && (r_sclk_prev != r_cpol);

    assign w_active = (r_state == SHIFT) && !w_cs_rise && !w_push;
    assign w_sample = w_active && (r_cpha ? w_trail : w_lead);
    // Bit 0 is already on miso after a reload, so the first drive edge of each byte is skipped.
    assign w_drive  = w_active && (r_cpha ? w_lead : w_trail) && (r_bitcnt != 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_reload   = 1'b0;
        w_push     = 1'b0;
        w_abort    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cs_fall) begin
                    w_state_nx = LOAD;
                end
            end
            LOAD: begin
                if (w_cs_rise) begin
                    w_state_nx = IDLE;
                end else begin
                    w_state_nx = SHIFT;
                    w_reload   = 1'b1;
                end
            end
            SHIFT: begin
                w_push = (r_bitcnt == 4'd8);
                if (w_cs_rise) begin
                    w_state_nx = IDLE;
                    w_abort    = (r_bitcnt != 4'd0) && (r_bitcnt != 4'd8);
                end else begin
                    w_reload = w_push;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    assign w_overrun = w_push && w_fifo_full && !bus.rx_pop;

    always_comb begin
        w_flag_set                   = '0;
        w_flag_set[FLAG_RX_OVERRUN]  = w_overrun;
        w_flag_set[FLAG_TX_UNDERRUN] = w_reload && !r_tx_full;
        w_flag_set[FLAG_FRAME_ABORT] = w_abort;
        w_flag_clr                   = bus.clr_flags ? bus.tx_data[2:0] : 3'b000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cpha    <= 1'b0;
            r_cpol    <= 1'b0;
            r_lsb     <= 1'b0;
            r_shift   <= '0;
            r_rx      <= '0;
            r_tx_hold <= '0;
            r_tx_full <= 1'b0;
            r_oe      <= 1'b0;
            r_bitcnt  <= '0;
            r_flags   <= '0;
        end else begin
            if (r_state == LOAD) begin
                r_cpha <= bus.conf[CONF_CPHA];
                r_cpol <= bus.conf[CONF_CPOL];
                r_lsb  <= bus.conf[CONF_LSB];
            end

            if (w_reload) begin
                r_shift <= r_tx_full ? r_tx_hold : IDLE_BYTE;
            end else if (w_drive) begin
                r_shift <= r_lsb ? {1'b0, r_shift[7:1]} : {r_shift[6:0], 1'b0};
            end

            if (w_sample) begin
                r_rx <= r_lsb ? {w_mosi_s, r_rx[7:1]} : {r_rx[6:0], w_mosi_s};
            end

            if ((w_state_nx != SHIFT) || w_push) begin
                r_bitcnt <= '0;
            end else if (w_sample) begin
                r_bitcnt <= r_bitcnt + 4'd1;
            end

            r_oe <= (w_state_nx == SHIFT);

            // A write landing on a reload refills the hold as the old byte leaves it.
            if (w_reload && r_tx_full) begin
                if (bus.tx_load) begin
                    r_tx_hold <= bus.tx_data;
                end else begin
                    r_tx_full <= 1'b0;
                end
            end else if (bus.tx_load && !r_tx_full) begin
                r_tx_hold <= bus.tx_data;
                r_tx_full <= 1'b1;
            end

            r_flags <= (r_flags & ~w_flag_clr) | w_flag_set;
        end
    end

    spi_slave_rx_fifo #(
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (r_rx),
        .i_pop   (bus.rx_pop),
        .o_data  (bus.rx_data),
        .o_count (bus.rx_count),
        .o_full  (w_fifo_full)
    );

    assign spi_miso    = r_oe && (r_lsb ? r_shift[0] : r_shift[7]);
    assign miso_oe     = r_oe;
    assign bus.tx_full = r_tx_full;
    assign bus.busy    = !w_cs_s && (r_state != IDLE);
    assign bus.flags   = r_flags;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a behavioural SPI master plus scoreboard queues for the
// bytes the master should read back and the bytes the RX FIFO should hold.
module tb_spi_slave;
    import cpu_io_pkg::*;

    localparam int HALF = 40;

    logic clk = 1'b0;
    logic rst;
    logic spi_sclk;
    logic spi_mosi;
    logic spi_cs_n;
    logic spi_miso;
    logic miso_oe;

    spi_slave_if bus_if();

    spi_slave #(
        .SYNC_STAGES (2),
        .RX_DEPTH    (4),
        .IDLE_BYTE   (8'hFF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_cs_n (spi_cs_n),
        .spi_miso (spi_miso),
        .miso_oe  (miso_oe),
        .bus      (bus_if)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [7:0]  exp_miso_q[$];
    logic [7:0]  exp_rx_q[$];
    logic        m_cpha;
    logic        m_cpol;
    logic        m_lsb;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_miso"},     spi_miso,        0);
        check_eq({tag, "_oe"},       miso_oe,         0);
        check_eq({tag, "_tx_full"},  bus_if.tx_full,  0);
        check_eq({tag, "_rx_count"}, bus_if.rx_count, 0);
        check_eq({tag, "_rx_data"},  bus_if.rx_data,  0);
        check_eq({tag, "_busy"},     bus_if.busy,     0);
        check_eq({tag, "_flags"},    bus_if.flags,    0);
    endtask

    task automatic set_mode(input logic [7:0] c);
        @(negedge clk);
        bus_if.conf = c;
        m_cpha      = c[0];
        m_cpol      = c[1];
        m_lsb       = c[2];
        spi_sclk    = c[1];
        repeat (4) @(negedge clk);
    endtask

    task automatic tx_write(input logic [7:0] d);
        @(negedge clk);
        bus_if.tx_data = d;
        bus_if.tx_load = 1'b1;
        @(negedge clk);
        bus_if.tx_load = 1'b0;
    endtask

    task automatic clear_flags(input logic [2:0] m);
        @(negedge clk);
        bus_if.tx_data   = {5'b0, m};
        bus_if.clr_flags = 1'b1;
        @(negedge clk);
        bus_if.clr_flags = 1'b0;
        @(negedge clk);
    endtask

    task automatic cs_assert();
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (15) @(negedge clk);
    endtask

    task automatic cs_release();
        #HALF;
        spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Master side of one byte; all pin changes stay on clk negedge instants.
    task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            int idx;
            idx = m_lsb ? i : 7 - i;
            if (!m_cpha) begin
                spi_mosi = tx[idx];
                #HALF;
                rx[idx]  = spi_miso;
                spi_sclk = ~m_cpol;
                #HALF;
                spi_sclk = m_cpol;
            end else begin
                #HALF;
                spi_sclk = ~m_cpol;
                spi_mosi = tx[idx];
                #HALF;
                rx[idx]  = spi_miso;
                spi_sclk = m_cpol;
            end
        end
    endtask

    task automatic do_byte(input string tag, input logic [7:0] tx, output logic [7:0] got);
        logic [7:0] e;
        spi_byte(tx, 8, got);
        check_eq({tag, "_sb_avail"}, exp_miso_q.size() != 0, 1);
        if (exp_miso_q.size() != 0) begin
            e = exp_miso_q.pop_front();
            check_eq({tag, "_miso"}, got, e);
        end
    endtask

    task automatic rx_drain_one(input string tag);
        logic [7:0] e;
        check_eq({tag, "_sb_avail"}, exp_rx_q.size() != 0, 1);
        if (exp_rx_q.size() != 0) begin
            e = exp_rx_q.pop_front();
            check_eq({tag, "_rx_data"}, bus_if.rx_data, e);
        end
        @(negedge clk);
        bus_if.rx_pop = 1'b1;
        @(negedge clk);
        bus_if.rx_pop = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [7:0]  got;
        int unsigned k;
        logic [4:0]  cnt_before;

        rst              = 1'b1;
        spi_sclk         = 1'b0;
        spi_mosi         = 1'b0;
        spi_cs_n         = 1'b1;
        bus_if.conf      = '0;
        bus_if.tx_data   = '0;
        bus_if.tx_load   = 1'b0;
        bus_if.rx_pop    = 1'b0;
        bus_if.clr_flags = 1'b0;
        m_cpha = 1'b0;
        m_cpol = 1'b0;
        m_lsb  = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_reset_outputs("post_rst");

        // Mode 0 single byte
        set_mode(8'h00);
        tx_write(8'h3C);
        check_eq("t1_tx_full_set", bus_if.tx_full, 1);
        exp_miso_q.push_back(8'h3C);
        exp_rx_q.push_back(8'hA5);
        cs_assert();
        check_eq("t1_busy", bus_if.busy, 1);
        do_byte("t1", 8'hA5, got);
        cs_release();
        check_eq("t1_rx_count", bus_if.rx_count, 1);
        check_eq("t1_tx_full_clr", bus_if.tx_full, 0);
        check_eq("t1_no_overrun", bus_if.flags[FLAG_RX_OVERRUN], 0);
        check_eq("t1_idle_oe", miso_oe, 0);
        rx_drain_one("t1");
        check_eq("t1_empty_count", bus_if.rx_count, 0);
        check_eq("t1_empty_data", bus_if.rx_data, 0);
        clear_flags(3'b111);

        // Mode 3, three back-to-back bytes, second TX byte loaded mid-frame
        set_mode(8'h03);
        tx_write(8'h44);
        exp_miso_q.push_back(8'h44);
        exp_miso_q.push_back(8'h55);
        exp_miso_q.push_back(8'hFF);
        exp_rx_q.push_back(8'h11);
        exp_rx_q.push_back(8'h22);
        exp_rx_q.push_back(8'h33);
        cs_assert();
        fork
            begin
                logic [7:0] g;
                do_byte("t2_b0", 8'h11, g);
                do_byte("t2_b1", 8'h22, g);
                do_byte("t2_b2", 8'h33, g);
            end
            begin
                int unsigned w;
                w = 0;
                while (bus_if.tx_full && w < 400) begin
                    @(negedge clk);
                    w++;
                end
                check_eq("t2_hold_free", bus_if.tx_full, 0);
                tx_write(8'h55);
            end
        join
        cs_release();
        check_eq("t2_underrun", bus_if.flags[FLAG_TX_UNDERRUN], 1);
        check_eq("t2_rx_count", bus_if.rx_count, 3);
        for (int i = 0; i < 3; i++) rx_drain_one("t2");
        clear_flags(3'b111);
        check_eq("t2_flags_clr", bus_if.flags, 0);

        // Overrun: five bytes into a four-deep FIFO
        set_mode(8'h00);
        cs_assert();
        for (int b = 1; b <= 5; b++) begin
            exp_miso_q.push_back(8'hFF);
            if (b <= 4) exp_rx_q.push_back(8'(b));
            do_byte("t3", 8'(b), got);
        end
        cs_release();
        check_eq("t3_rx_count", bus_if.rx_count, 4);
        check_eq("t3_head", bus_if.rx_data, 8'h01);
        check_eq("t3_overrun", bus_if.flags[FLAG_RX_OVERRUN], 1);
        clear_flags(3'b001);
        check_eq("t3_w1c_bit0", bus_if.flags, 3'b010);
        clear_flags(3'b111);
        check_eq("t3_flags_clr", bus_if.flags, 0);
        for (int i = 0; i < 4; i++) rx_drain_one("t3");
        check_eq("t3_drained", bus_if.rx_count, 0);

        // Frame abort after three bits
        cnt_before = bus_if.rx_count;
        cs_assert();
        spi_byte(8'h96, 3, got);
        spi_cs_n = 1'b1;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (miso_oe && k < 10);
        check_eq("t4_oe_low", miso_oe, 0);
        check_eq("t4_oe_latency_ok", k <= 3, 1);
        check_eq("t4_miso_low", spi_miso, 0);
        repeat (6) @(negedge clk);
        check_eq("t4_rx_count", bus_if.rx_count, cnt_before);
        check_eq("t4_abort", bus_if.flags[FLAG_FRAME_ABORT], 1);
        check_eq("t4_busy", bus_if.busy, 0);
        clear_flags(3'b111);

        // LSB-first, mode 0
        set_mode(8'h04);
        tx_write(8'h01);
        exp_miso_q.push_back(8'h01);
        exp_rx_q.push_back(8'h80);
        cs_assert();
        do_byte("t5", 8'h80, got);
        check_eq("t5_first_bit", got[0], 1);
        cs_release();
        rx_drain_one("t5");
        clear_flags(3'b111);

        // Reset mid-byte with cs_n held low
        set_mode(8'h00);
        tx_write(8'h77);
        cs_assert();
        spi_byte(8'hF0, 4, got);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("t6_in_rst");
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check_eq("t6_no_frame_busy", bus_if.busy, 0);
        check_eq("t6_no_frame_oe", miso_oe, 0);
        check_eq("t6_no_frame_tx_full", bus_if.tx_full, 0);
        spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
        tx_write(8'h5A);
        exp_miso_q.push_back(8'h5A);
        exp_rx_q.push_back(8'hC3);
        cs_assert();
        do_byte("t6", 8'hC3, got);
        cs_release();
        check_eq("t6_rx_count", bus_if.rx_count, 1);
        check_eq("t6_no_abort", bus_if.flags[FLAG_FRAME_ABORT], 0);
        check_eq("t6_no_overrun", bus_if.flags[FLAG_RX_OVERRUN], 0);
        rx_drain_one("t6");

        check_eq("sb_miso_left", exp_miso_q.size(), 0);
        check_eq("sb_rx_left", exp_rx_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
